s4_writeback_regfile: RTL and testbench

S4_WRITEBACK_REGFILE -- requirements
Module: s4_writeback_regfile

---
 rtl/s4_writeback_regfile.sv | 103 ++++++++++
 tb/tb_s4_writeback_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/s4_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : s4_writeback_regfile
//  Purpose  : Stage-4 writeback register plus 32x32 register file with two
//             combinational read ports. Entry 0 is hard-wired to zero.
//             Optional macro WB_BYPASS_EN: a pending S4 write whose select
//             matches a read address is forwarded to that read port.
//  Revision : 1.0  initial release
// ============================================================================
module s4_writeback_regfile #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,        // asynchronous, active-low
   input  logic [31:0] S3_ALUOut,
   input  logic [4:0]  S3_WS,
   input  logic        S3_WE,
   input  logic [4:0]  Reg_RA1,
   input  logic [4:0]  Reg_RA2,
   output logic [31:0] Reg_RD1,
   output logic [31:0] Reg_RD2,
   output logic [31:0] S4_WD,
   output logic [4:0]  S4_WS,
   output logic        S4_WE
);

   logic [31:0] r_wd;
   logic [4:0]  r_ws;
   logic        r_we;
   logic [31:0] r_file [0:31];

   logic        w_commit;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;

   // A held write lands in the file only when enabled and not aimed at entry 0
   assign w_commit = r_we && (r_ws != 5'd0);

   // Capture the execute-stage result and commit the previously held one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd <= 32'h0000_0000;
         r_ws <= 5'd0;
         r_we <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_file[i] <= (i == 0) ? 32'h0000_0000 : RESET_VAL;
         end
      end else begin
         r_wd <= S3_ALUOut;
         r_ws <= S3_WS;
         r_we <= S3_WE;
         if (w_commit) begin
            r_file[r_ws] <= r_wd;
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Read port 1: zero for entry 0, pending S4 data on a select match, else file
   always_comb begin
      w_rd1 = r_file[Reg_RA1];
      if (Reg_RA1 == 5'd0) begin
         w_rd1 = 32'h0000_0000;
      end else if (w_commit && (r_ws == Reg_RA1)) begin
         w_rd1 = r_wd;
      end
   end

   // Read port 2: same selection as port 1 using its own address
   always_comb begin
      w_rd2 = r_file[Reg_RA2];
      if (Reg_RA2 == 5'd0) begin
         w_rd2 = 32'h0000_0000;
      end else if (w_commit && (r_ws == Reg_RA2)) begin
         w_rd2 = r_wd;
      end
   end
`else
   // Read port 1: file contents only, entry 0 forced to zero
   always_comb begin
      w_rd1 = r_file[Reg_RA1];
      if (Reg_RA1 == 5'd0) begin
         w_rd1 = 32'h0000_0000;
      end
   end

   // Read port 2: file contents only, entry 0 forced to zero
   always_comb begin
      w_rd2 = r_file[Reg_RA2];
      if (Reg_RA2 == 5'd0) begin
         w_rd2 = 32'h0000_0000;
      end
   end
`endif

   assign Reg_RD1 = w_rd1;
   assign Reg_RD2 = w_rd2;
   assign S4_WD   = r_wd;
   assign S4_WS   = r_ws;
   assign S4_WE   = r_we;

endmodule
`default_nettype wire

// File: tb/tb_s4_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s4_writeback_regfile
//  Purpose  : Self-checking bench for s4_writeback_regfile: directed scenarios
//             with literal expectations, then randomized traffic compared
//             every cycle against a behavioural model of the register file.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s4_writeback_regfile;

   localparam logic [31:0] RV = 32'h0BAD_F00D;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] S3_ALUOut = '0;
   logic [4:0]  S3_WS = '0;
   logic        S3_WE = 1'b0;
   logic [4:0]  Reg_RA1 = '0;
   logic [4:0]  Reg_RA2 = '0;
   logic [31:0] Reg_RD1, Reg_RD2, S4_WD;
   logic [4:0]  S4_WS;
   logic        S4_WE;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   s4_writeback_regfile #(.RESET_VAL(RV)) dut (
      .clk(clk), .rst(rst),
      .S3_ALUOut(S3_ALUOut), .S3_WS(S3_WS), .S3_WE(S3_WE),
      .Reg_RA1(Reg_RA1), .Reg_RA2(Reg_RA2),
      .Reg_RD1(Reg_RD1), .Reg_RD2(Reg_RD2),
      .S4_WD(S4_WD), .S4_WS(S4_WS), .S4_WE(S4_WE)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Architectural contents plus the one write that is in flight.
   logic [31:0] m_reg [32];
   logic [31:0] m_wd;
   logic [4:0]  m_ws;
   logic        m_we;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         foreach (m_reg[i]) m_reg[i] = (i == 0) ? 32'h0 : RV;
         m_wd = 32'h0; m_ws = 5'd0; m_we = 1'b0;
      end else begin
         // the write captured last cycle becomes architectural now
         if (m_we && m_ws != 0) m_reg[m_ws] = m_wd;
         m_wd = S3_ALUOut; m_ws = S3_WS; m_we = S3_WE;
      end
   end

   function automatic logic [31:0] m_read(input logic [4:0] ra);
      if (ra == 0) return 32'h0;
      if (BYP && m_we && m_ws == ra) return m_wd;
      return m_reg[ra];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // literal expectation applied to the DUT and to the model alike
   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                      input logic [31:0] exp);
      check(name, act, exp);
      check({name, "_model"}, mdl, exp);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_S4_WD", S4_WD, m_wd);
         check("cyc_S4_WS", {27'd0, S4_WS}, {27'd0, m_ws});
         check("cyc_S4_WE", {31'd0, S4_WE}, {31'd0, m_we});
         check("cyc_RD1", Reg_RD1, m_read(Reg_RA1));
         check("cyc_RD2", Reg_RD2, m_read(Reg_RA2));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] ws, input logic we, input logic [31:0] d);
      S3_WS = ws; S3_WE = we; S3_ALUOut = d;
   endtask

   initial begin
      // ---- reset state, asserted between edges ----
      #1 rst = 1'b0;
      #2;
      chk_en = 1'b1;
      check("rst_S4_WE", {31'd0, S4_WE}, 32'd0);
      check("rst_S4_WD", S4_WD, 32'd0);
      Reg_RA1 = 5'd0; Reg_RA2 = 5'd17;
      #1;
      pin("rst_RD1_a0", Reg_RD1, m_read(Reg_RA1), 32'd0);
      pin("rst_RD2_a17", Reg_RD2, m_read(Reg_RA2), RV);
      tick();
      rst = 1'b1;

      // ---- basic write to r5 ----
      Reg_RA1 = 5'd5; Reg_RA2 = 5'd0;
      drive(5'd5, 1'b1, 32'hDEAD_BEEF);
      tick();
      pin("wr5_S4_WD", S4_WD, m_wd, 32'hDEAD_BEEF);
      pin("wr5_RD1_e1", Reg_RD1, m_read(Reg_RA1), BYP ? 32'hDEAD_BEEF : RV);
      drive(5'd0, 1'b0, 32'h0);
      tick();
      pin("wr5_RD1_e2", Reg_RD1, m_read(Reg_RA1), 32'hDEAD_BEEF);

      // ---- writes to r0 are discarded ----
      Reg_RA1 = 5'd0; Reg_RA2 = 5'd0;
      drive(5'd0, 1'b1, 32'hFFFF_FFFF);
      tick();
      pin("r0_RD1_e1", Reg_RD1, m_read(Reg_RA1), 32'd0);
      pin("r0_RD2_e1", Reg_RD2, m_read(Reg_RA2), 32'd0);
      drive(5'd0, 1'b0, 32'h0);
      tick();
      pin("r0_RD1_e2", Reg_RD1, m_read(Reg_RA1), 32'd0);

      // ---- back-to-back writes to r7 ----
      Reg_RA1 = 5'd7; Reg_RA2 = 5'd7;
      drive(5'd7, 1'b1, 32'h1);
      tick();
      pin("b2b_RD2_a", Reg_RD2, m_read(Reg_RA2), BYP ? 32'h1 : RV);
      drive(5'd7, 1'b1, 32'h2);
      tick();
      pin("b2b_RD2_b", Reg_RD2, m_read(Reg_RA2), BYP ? 32'h2 : 32'h1);
      check("b2b_RD1_eq_RD2", Reg_RD1, BYP ? 32'h2 : 32'h1);
      drive(5'd0, 1'b0, 32'h0);
      tick();
      pin("b2b_RD2_c", Reg_RD2, m_read(Reg_RA2), 32'h2);

      // ---- write enable low ----
      Reg_RA1 = 5'd9; Reg_RA2 = 5'd9;
      drive(5'd9, 1'b0, 32'h1234);
      tick();
      pin("we0_S4_WS", {27'd0, S4_WS}, {27'd0, m_ws}, 32'd9);
      pin("we0_S4_WE", {31'd0, S4_WE}, {31'd0, m_we}, 32'd0);
      pin("we0_RD1_e1", Reg_RD1, m_read(Reg_RA1), RV);
      drive(5'd0, 1'b0, 32'h0);
      tick();
      pin("we0_RD1_e2", Reg_RD1, m_read(Reg_RA1), RV);

      // ---- reset while a write is pending ----
      Reg_RA1 = 5'd3; Reg_RA2 = 5'd5;
      drive(5'd3, 1'b1, 32'h55);
      tick();
      check("pend_S4_WE", {31'd0, S4_WE}, 32'd1);
      drive(5'd0, 1'b0, 32'h0);
      #2 rst = 1'b0;
      #1;
      pin("mrst_S4_WE", {31'd0, S4_WE}, {31'd0, m_we}, 32'd0);
      pin("mrst_RD1_r3", Reg_RD1, m_read(Reg_RA1), RV);
      pin("mrst_RD2_r5", Reg_RD2, m_read(Reg_RA2), RV);
      tick();
      rst = 1'b1;
      tick();
      tick();
      pin("mrst_RD1_after", Reg_RD1, m_read(Reg_RA1), RV);

      // ---- randomized traffic ----
      for (int c = 0; c < 2000; c++) begin
         S3_WS     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         S3_WE     = 1'($urandom_range(0, 3) != 0);
         S3_ALUOut = $urandom;
         Reg_RA1   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         Reg_RA2   = ($urandom_range(0, 1) == 0) ? S3_WS : 5'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b0;
            tick();
            rst = 1'b1;
         end else begin
            tick();
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
